boot_sequencer: RTL

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// Boot sequencer for a pulpino_top core: holds the core in reset, releases it, runs
// three agent handshakes (SPI program load, JTAG transfer, SPI readback), then enables
// instruction fetch.
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   start_i          - level request for a boot sequence
//   spi_done_i       - SPI agent finished the current transfer
//   jtag_done_i      - JTAG agent finished its transfer
//   spi_start1_o     - one-cycle launch of the SPI program load
//   spi_start2_o     - one-cycle launch of the SPI readback/check
//   jtag_start_o     - one-cycle launch of the JTAG transfer
//   core_rst_n_o     - active-low core reset
//   fetch_enable_o   - core fetch enable
//   busy_o/done_o/error_o - sequence in progress / running / failed
//   state_o          - current state encoding
module boot_sequencer #(
  parameter int unsigned DELAY_CYCLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       spi_done_i,
  input  logic       jtag_done_i,
  output logic       spi_start1_o,
  output logic       spi_start2_o,
  output logic       jtag_start_o,
  output logic       core_rst_n_o,
  output logic       fetch_enable_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StHoldRst   = 4'd1,
    StRelWait   = 4'd2,
    StSpi1      = 4'd3,
    StJtag      = 4'd4,
    StSpi2      = 4'd5,
    StFetchWait = 4'd6,
    StRun       = 4'd7,
    StErr       = 4'd8
  } state_e;

  localparam logic [15:0] DelayLast   = 16'(DELAY_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        first_cycle;
  logic        timed_out;

  logic spi_start1_d, spi_start2_d, jtag_start_d;
  logic core_rst_n_d, fetch_enable_d, busy_d, done_d, error_d;

  // Done is ignored in the cycle that issues the start pulse.
  assign first_cycle = (cnt_q == 16'd0);
  assign timed_out   = (cnt_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start_i) state_d = StHoldRst;
      StHoldRst:   if (cnt_q == DelayLast) state_d = StRelWait;
      StRelWait:   if (cnt_q == DelayLast) state_d = StSpi1;
      // Done is checked before timeout so a late done still wins.
      StSpi1: begin
        if (!first_cycle && spi_done_i)  state_d = StJtag;
        else if (timed_out)              state_d = StErr;
      end
      StJtag: begin
        if (!first_cycle && jtag_done_i) state_d = StSpi2;
        else if (timed_out)              state_d = StErr;
      end
      StSpi2: begin
        if (!first_cycle && spi_done_i)  state_d = StFetchWait;
        else if (timed_out)              state_d = StErr;
      end
      StFetchWait: if (cnt_q == DelayLast) state_d = StRun;
      StRun:       if (!start_i) state_d = StIdle;
      StErr:       if (!start_i) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Phase counter restarts on every state entry and saturates instead of wrapping.
  always_comb begin
    if (state_d != state_q)     cnt_d = 16'd0;
    else if (cnt_q == 16'hFFFF) cnt_d = cnt_q;
    else                        cnt_d = cnt_q + 16'd1;
  end

  // Outputs are decoded from the next state so the registered copies line up with state_o.
  always_comb begin
    spi_start1_d   = (state_d == StSpi1) && (state_q != StSpi1);
    jtag_start_d   = (state_d == StJtag) && (state_q != StJtag);
    spi_start2_d   = (state_d == StSpi2) && (state_q != StSpi2);
    core_rst_n_d   = !((state_d == StIdle) || (state_d == StHoldRst) || (state_d == StErr));
    fetch_enable_d = (state_d == StRun);
    busy_d         = !((state_d == StIdle) || (state_d == StRun) || (state_d == StErr));
    done_d         = (state_d == StRun);
    error_d        = (state_d == StErr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= 16'd0;
      spi_start1_o   <= 1'b0;
      spi_start2_o   <= 1'b0;
      jtag_start_o   <= 1'b0;
      core_rst_n_o   <= 1'b0;
      fetch_enable_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      spi_start1_o   <= spi_start1_d;
      spi_start2_o   <= spi_start2_d;
      jtag_start_o   <= jtag_start_d;
      core_rst_n_o   <= core_rst_n_d;
      fetch_enable_o <= fetch_enable_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      error_o        <= error_d;
    end
  end

  assign state_o = state_q;

endmodule
